mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory port (address bus, data bus, mem_rd/mem_wr strobes) between two masters.
- Master 0 is the CPU control path; master 1 is the program loader/DMA.
- Grants one complete access at a time, inserts WAIT_CYCLES memory wait states, and returns read data plus a one-cycle ack.
- Round-robin fairness when both masters request in the same cycle.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 2, cycles mem_rd/mem_wr stay asserted per access; legal range 1..15.

Ports:
- clock  in  1  main clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request; held high until m0_ack.
- m0_wr  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 owns the bus.
- m0_ack  out  1  one-cycle completion pulse for master 0.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_ack: same as m0, for master 1.
- rdata  out  DATA_W  read data of the last completed read; valid with ack.
- mem_addr  out  ADDR_W  external memory address.
- mem_wdata  out  DATA_W  external write data.
- mem_rd  out  1  external read enable.
- mem_wr  out  1  external write enable.
- mem_rdata  in  DATA_W  external read data.

Behaviour:
- Reset (async, reset=0): state IDLE; all gnt, ack, mem_rd, mem_wr = 0; mem_addr, mem_wdata, rdata = 0; wait counter = 0; last_gnt = 1, so m0 wins the first tie.
- States: IDLE, ACCESS, DONE. Binary encoding; illegal states return to IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master != last_gnt.
  - On grant, at the clock edge: latch addr/wdata/wr of the winner into mem_addr/mem_wdata/an internal wr flag; set last_gnt; load counter = WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - Winner's gnt = 1; mem_rd = !wr; mem_wr = wr; mem_addr/mem_wdata held stable.
  - Counter decrements each cycle.
  - When counter = 0: on that edge, for a read, rdata <= mem_rdata; go to DONE.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- DONE:
  - Winner's gnt = 1 and ack = 1 for one cycle; mem_rd = mem_wr = 0; go to IDLE.
  - For writes, rdata keeps its previous value.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the IDLE edge that sampled req.
- Minimum access period: WAIT_CYCLES+2 cycles, including one IDLE turnaround cycle.
- Masters drop req in the ack cycle or the cycle after. A master holding req through IDLE is re-arbitrated as a new request; with round-robin the other pending master wins.
- Req dropped during ACCESS: the access is not aborted; it completes and ack is still pulsed.
- Req/addr/wdata changes after grant: ignored, since values are latched.
- Outputs gnt, ack, mem_rd, mem_wr are registered or decoded from state only; no combinational path from req.
- Reset asserted mid-ACCESS: strobes and gnt drop immediately (asynchronously); no ack is generated; the access is lost.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: m0 always wins a tie; last_gnt has no effect on selection.
- Undefined: round-robin tie-break as described above.
- All other timing is identical in both builds.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encodings ST_IDLE, ST_ACCESS, ST_DONE.
  - Master ids M0 = 1'b0, M1 = 1'b1.
  - Counter width constant WAIT_CNT_W = 4.
- One natural sub-module: arb_rr_pick.
  - Combinational winner select.
  - Inputs: req0, req1, last_gnt.
  - Outputs: valid, winner.
  - The ARB_FIXED_PRIO_EN switch lives here.
- Everything else stays in mem_bus_arbiter.

Test Plan:
- Reset check: drive reset=0 asynchronously mid-cycle -> all outputs 0 at once. Release and hold idle 5 cycles -> no gnt, no strobes.
- Single read (WAIT_CYCLES=2): m0 reads addr 0x0040, memory returns 0xBEEF.
  - mem_rd=1 and mem_addr=0x0040 for exactly 2 cycles.
  - m0_ack pulses 3 cycles after the sampling edge with rdata=0xBEEF.
  - m1_gnt stays 0.
- Single write: m1 writes 0x1234 to 0x00FF -> mem_wr=1 for 2 cycles with mem_wdata=0x1234; m1_ack pulses once; rdata unchanged.
- Contention: both req continuously for 4 accesses, each master dropping req in its ack cycle and re-raising after.
  - Grant order m0, m1, m0, m1.
  - With ARB_FIXED_PRIO_EN: m0 wins every tie.
- Req drop and reset abort:
  - m0 drops req in the 1st ACCESS cycle -> access completes and ack is still pulsed.
  - Separately, assert reset in the 2nd ACCESS cycle -> mem_rd falls the same cycle; no ack; after release, state is IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory bus arbiter: FSM states, master ids, wait counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select for two requesters.
// ARB_FIXED_PRIO_EN: when defined, m0 wins every tie; otherwise ties alternate away from last_gnt.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    valid  = req0 | req1;
    winner = M0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = M0;
`else
      winner = ~last_gnt;
`endif
    end else if (req1) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between two masters: one latched access at a time,
// WAIT_CYCLES strobe cycles, then a one-cycle ack. Tie-break mode set by ARB_FIXED_PRIO_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  wr_q;
  logic                  owner;
  logic                  last_gnt;
  logic                  pick_valid;
  logic                  pick_winner;

  arb_rr_pick u_pick (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      owner     <= M0;
      last_gnt  <= M1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner     <= pick_winner;
            last_gnt  <= pick_winner;
            wr_q      <= pick_winner ? m1_wr    : m0_wr;
            mem_addr  <= pick_winner ? m1_addr  : m0_addr;
            mem_wdata <= pick_winner ? m1_wdata : m0_wdata;
            cnt       <= CNT_LOAD;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Last strobe cycle: capture memory data on the same edge that leaves ACCESS.
          if (cnt == '0) begin
            if (!wr_q) rdata <= mem_rdata;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode state only, so async reset drops them immediately.
  logic busy, done;
  assign busy   = (state == ST_ACCESS) || (state == ST_DONE);
  assign done   = (state == ST_DONE);
  assign m0_gnt = busy && (owner == M0);
  assign m1_gnt = busy && (owner == M1);
  assign m0_ack = done && (owner == M0);
  assign m1_ack = done && (owner == M1);
  assign mem_rd = (state == ST_ACCESS) && !wr_q;
  assign mem_wr = (state == ST_ACCESS) && wr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an ack scoreboard and a simple memory model.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WAIT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, rdata, mem_rdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack, mem_rd, mem_wr;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdata = memval(mem_addr);

  typedef struct {
    logic          m;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] last_model = '0;
  int            nchecks = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic wr, input logic [AW-1:0] addr);
    exp_t e;
    e.m        = m;
    e.rdata    = wr ? last_model : memval(addr);
    last_model = e.rdata;
    sb.push_back(e);
  endtask

  task automatic drive(input logic m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic drop(input logic m);
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {26'd0, m0_gnt, m0_ack, m1_gnt, m1_ack, mem_rd, mem_wr}, 32'd0);
  endtask

  // One access from an idle bus; called at a falling edge.
  task automatic access(input logic m, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int drop_n);
    int n = 0;
    int strobes = 0;
    bit acked = 0;
    drive(m, wr, a, d);
    push(m, wr, a);
    @(posedge clock);
    while (!acked && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        // Scramble the request fields; the latched values must hold.
        if (m) begin m1_addr = ~a; m1_wdata = ~d; end
        else   begin m0_addr = ~a; m0_wdata = ~d; end
      end
      if (mem_rd || mem_wr) strobes++;
      if (n <= WAIT) begin
        chk("own_gnt", m ? m1_gnt : m0_gnt, 1);
        chk("strobe", {mem_rd, mem_wr}, wr ? 2'b01 : 2'b10);
        chk("mem_addr", mem_addr, a);
        if (wr) chk("mem_wdata", mem_wdata, d);
      end
      chk("other_gnt", m ? m0_gnt : m1_gnt, 0);
      if (m ? m1_ack : m0_ack) begin
        acked = 1;
        chk("ack_latency", n, WAIT + 1);
        chk("ack_strobe_off", {mem_rd, mem_wr}, 0);
        drop(m);
      end
      if (n == drop_n) drop(m);
    end
    chk("ack_seen", acked, 1);
    chk("strobe_cycles", strobes, WAIT);
    @(negedge clock);
    chk_quiet("turnaround_idle");
  endtask

  // Scoreboard: every ack pops the expected master and read data.
  always @(negedge clock) begin
    if (reset === 1'b1 && (m0_ack || m1_ack)) begin
      chk("ack_expected", sb.size() != 0, 1);
      chk("ack_onehot", m0_ack & m1_ack, 0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_master", m1_ack, e.m);
        chk("rdata", rdata, e.rdata);
      end
    end
  end

  initial begin
    int acks;
    bit rearm0, rearm1;
    reset = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(negedge clock);
    chk_quiet("reset_ctrl");
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_rdata", rdata, 0);
    reset = 1'b1;
    repeat (5) begin @(negedge clock); chk_quiet("idle_after_reset"); end

    access(1'b0, 1'b0, 16'h0040, 16'h0000, 0);
    chk("read_rdata_hold", rdata, 16'hBEEF);
    access(1'b1, 1'b1, 16'h00FF, 16'h1234, 0);
    chk("write_keeps_rdata", rdata, 16'hBEEF);

    // Reset lands in the 2nd ACCESS cycle of an m1 read; that access is lost.
    drive(1'b1, 1'b0, 16'h0400, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("abort_rd_before", mem_rd, 1);
    #2 reset = 1'b0;
    #1;
    chk_quiet("abort_async_ctrl");
    chk("abort_async_addr", mem_addr, 0);
    chk("abort_async_wdata", mem_wdata, 0);
    chk("abort_async_rdata", rdata, 0);
    m1_req = 1'b0;
    sb.delete();
    last_model = '0;
    repeat (2) begin @(negedge clock); chk_quiet("in_reset"); end
    reset = 1'b1;
    repeat (5) begin @(negedge clock); chk_quiet("idle_after_abort"); end

    // Contention: both masters keep requesting, each re-raising after its ack.
    drive(1'b0, 1'b0, 16'h0100, 16'h0000);
    drive(1'b1, 1'b0, 16'h0200, 16'h0000);
`ifdef ARB_FIXED_PRIO_EN
    repeat (4) push(1'b0, 1'b0, 16'h0100);
`else
    push(1'b0, 1'b0, 16'h0100);
    push(1'b1, 1'b0, 16'h0200);
    push(1'b0, 1'b0, 16'h0100);
    push(1'b1, 1'b0, 16'h0200);
`endif
    acks = 0; rearm0 = 0; rearm1 = 0;
    for (int c = 0; c < 80 && acks < 4; c++) begin
      @(negedge clock);
      if (rearm0) begin m0_req = 1'b1; rearm0 = 0; end
      if (rearm1) begin m1_req = 1'b1; rearm1 = 0; end
      if (m0_ack) begin acks++; m0_req = 1'b0; rearm0 = 1; end
      if (m1_ack) begin acks++; m1_req = 1'b0; rearm1 = 1; end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("contention_acks", acks, 4);
    repeat (2) @(negedge clock);
    chk_quiet("idle_after_contention");

    // m0 drops req in the first ACCESS cycle; the access still completes.
    access(1'b0, 1'b0, 16'h0300, 16'h0000, 1);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
